multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I core: steps FETCH/DECODE/EXEC/MEM/WB over the shared
//  ALU, register file and a single unified memory port with a req/ready handshake.

---
 rtl/riscv_ctrl_pkg.sv | 106 ++++++++++
 rtl/multicycle_ctrl_fsm_alu_op_decoder.sv | 53 +++++
 rtl/multicycle_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle sequencer:
// opcodes, ALU/PC/WB select codes, FSM states and instruction classes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MDR = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILL    = 4'd0,
    CLS_OP     = 4'd1,
    CLS_OPIMM  = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } cls_e;

  // Per-state outputs that do not depend on mem_ready/branch_cond.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_write;
    logic [1:0] pc_src;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
  } moore_t;

  function automatic cls_e opcode_class(input logic [6:0] opc);
    cls_e c;
    case (opc)
      OPC_OP:     c = CLS_OP;
      OPC_OPIMM:  c = CLS_OPIMM;
      OPC_LOAD:   c = CLS_LOAD;
      OPC_STORE:  c = CLS_STORE;
      OPC_BRANCH: c = CLS_BRANCH;
      OPC_JAL:    c = CLS_JAL;
      OPC_JALR:   c = CLS_JALR;
      OPC_LUI:    c = CLS_LUI;
      OPC_AUIPC:  c = CLS_AUIPC;
      default:    c = CLS_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] alu_from_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_op_decoder.sv
// Maps {instruction class, funct3, funct7} to an ALU operation and
// a legality flag; shared with the single-cycle control path.
module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [3:0] cls,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       legal
);

  logic f7_zero;
  logic f7_alt;

  assign f7_zero = (funct7 == 7'h00);
  assign f7_alt  = (funct7 == 7'h20);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (cls)
      CLS_OP: begin
        alu_op = alu_from_f3(funct3, funct7[5]);
        legal  = f7_zero ||
                 (f7_alt && (funct3 == 3'b000 ||
                             funct3 == 3'b101));
      end
      CLS_OPIMM: begin
        // No SUBI: only the shift-right immediate uses funct7[5].
        alu_op = alu_from_f3(funct3,
                   (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)
          legal = f7_zero;
        else if (funct3 == 3'b101)
          legal = f7_zero || f7_alt;
      end
      CLS_LOAD, CLS_STORE: begin
        legal = (funct3 == 3'b010);
      end
      CLS_BRANCH: begin
        alu_op = ALU_SUB;
      end
      CLS_ILL: begin
        legal = 1'b0;
      end
      default: begin
        alu_op = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over a
// unified req/ready memory port, with illegal-op and timeout traps.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [2:0] state_dbg,
  output logic       trap,
  output logic       trap_cause
);

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e     state_q, state_d;
  logic [3:0] cls_q, cls_d;
  logic [3:0] aop_q, aop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       cause_q, cause_d;
  moore_t     out_q, out_d;

  cls_e       dec_cls;
  logic [3:0] dec_aop;
  logic       dec_legal;
  logic       in_mem_phase;

  assign dec_cls = opcode_class(opcode);

  alu_op_decoder u_dec (
    .cls    (dec_cls),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_aop),
    .legal  (dec_legal)
  );

  function automatic moore_t moore_of(
    input state_e     s,
    input logic [3:0] c,
    input logic [3:0] op
  );
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.mem_req = 1'b1;
      end
      S_EXEC, S_WB: begin
        m.alu_op    = op;
        m.alu_src_a = (c == CLS_AUIPC);
        m.alu_src_b = (c == CLS_OPIMM) ||
                      (c == CLS_LOAD)  ||
                      (c == CLS_STORE) ||
                      (c == CLS_AUIPC) ||
                      (c == CLS_JALR);
        if (s == S_WB) begin
          m.reg_write = 1'b1;
          m.wb_sel    = (c == CLS_LOAD) ?
                        WB_SEL_MDR : WB_SEL_ALU;
        end else begin
          case (c)
            CLS_LUI: begin
              m.reg_write = 1'b1;
              m.wb_sel    = WB_SEL_IMM;
            end
            CLS_BRANCH: begin
              m.pc_src = PC_SRC_BR;
            end
            CLS_JAL: begin
              m.pc_src    = PC_SRC_BR;
              m.reg_write = 1'b1;
              m.wb_sel    = WB_SEL_PC4;
            end
            CLS_JALR: begin
              m.pc_src    = PC_SRC_JALR;
              m.reg_write = 1'b1;
              m.wb_sel    = WB_SEL_PC4;
            end
            default: begin
              m.pc_src = PC_SRC_PC4;
            end
          endcase
        end
      end
      S_MEM: begin
        m.mem_req      = 1'b1;
        m.mem_addr_sel = 1'b1;
        m.mem_we       = (c == CLS_STORE);
        m.alu_op       = ALU_ADD;
        m.alu_src_b    = 1'b1;
      end
      default: begin
        m = '0;
      end
    endcase
    return m;
  endfunction

  assign in_mem_phase =
    (state_q == S_FETCH) || (state_q == S_MEM);

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    aop_d     = aop_q;
    cause_d   = cause_q;
    cnt_d     = '0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        aop_d = dec_aop;
        if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = 1'b0;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CLS_OP, CLS_OPIMM, CLS_AUIPC:
            state_d = S_WB;
          CLS_LOAD, CLS_STORE:
            state_d = S_MEM;
          CLS_BRANCH: begin
            pc_write = branch_cond;
            state_d  = S_FETCH;
          end
          CLS_JAL, CLS_JALR: begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          default:
            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB:   state_d = S_FETCH;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    // Wait-cycle watchdog; trap entry overrides any transition above.
    if (MEM_TIMEOUT != 0 && in_mem_phase && !mem_ready) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CW'(MEM_TIMEOUT)) begin
        state_d = S_TRAP;
        cause_d = 1'b1;
      end
    end

    out_d = moore_of(state_d, cls_d, aop_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= '0;
      aop_q   <= '0;
      cnt_q   <= '0;
      cause_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      aop_q   <= aop_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      out_q   <= out_d;
    end
  end

  assign mem_req      = out_q.mem_req;
  assign mem_we       = out_q.mem_we;
  assign mem_addr_sel = out_q.mem_addr_sel;
  assign reg_write    = out_q.reg_write;
  assign pc_src       = out_q.pc_src;
  assign wb_sel       = out_q.wb_sel;
  assign alu_op       = out_q.alu_op;
  assign alu_src_a    = out_q.alu_src_a;
  assign alu_src_b    = out_q.alu_src_b;
  assign state_dbg    = state_q;
  assign trap         = (state_q == S_TRAP);
  assign trap_cause   = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: state sequences, enables,
// illegal/timeout traps and asynchronous reset mid-access.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       branch_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel;
  logic       ir_write, mdr_write, pc_write;
  logic [1:0] pc_src, wb_sel;
  logic       reg_write;
  logic [3:0] alu_op;
  logic       alu_src_a, alu_src_b;
  logic [2:0] state_dbg;
  logic       trap, trap_cause;

  int passed = 0;
  int total  = 0;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .branch_cond  (branch_cond),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .mdr_write    (mdr_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .state_dbg    (state_dbg),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [31:0] w);
    opcode = w[6:0];
    funct3 = w[14:12];
    funct7 = w[31:25];
  endtask

  // Leaves the bench at a falling edge with the DUT in FETCH.
  task automatic start();
    rst = 1'b1;
    mem_ready = 1'b0;
    branch_cond = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [22:0] all;
    rst = 1'b1;
    mem_ready = 1'b1;
    nxt(); nxt(); #1;
    all = {mem_req, mem_we, mem_addr_sel, ir_write,
           mdr_write, pc_write, pc_src, reg_write,
           wb_sel, alu_op, alu_src_a, alu_src_b,
           state_dbg, trap, trap_cause};
    total++;
    if (all !== 23'd0)
      $display("FAIL reset_outputs got %h exp 0", all);
    else passed++;
    mem_ready = 1'b0;
    nxt(); rst = 1'b0; #1;
    total++;
    if (state_dbg !== 3'd0 || mem_req !== 1'b0)
      $display("FAIL reset_release state=%0d req=%b exp 0/0",
               state_dbg, mem_req);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd1 || mem_req !== 1'b1)
      $display("FAIL first_fetch state=%0d req=%b exp 1/1",
               state_dbg, mem_req);
    else passed++;
  endtask

  task automatic test_add();
    start();
    set_ir(32'h0020_8033);
    mem_ready = 1'b1; #1;
    total++;
    if (state_dbg !== 3'd1 || ir_write !== 1'b1 ||
        pc_write !== 1'b1 || pc_src !== 2'b00 ||
        mem_addr_sel !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL add_fetch st=%0d ir=%b pw=%b ps=%b as=%b we=%b exp 1,1,1,00,0,0",
               state_dbg, ir_write, pc_write, pc_src,
               mem_addr_sel, mem_we);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd2 || reg_write !== 1'b0 ||
        mem_req !== 1'b0 || ir_write !== 1'b0)
      $display("FAIL add_decode st=%0d rw=%b req=%b ir=%b exp 2,0,0,0",
               state_dbg, reg_write, mem_req, ir_write);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd3 || reg_write !== 1'b0 ||
        alu_op !== 4'b0000 || alu_src_b !== 1'b0)
      $display("FAIL add_exec st=%0d rw=%b op=%b sb=%b exp 3,0,0000,0",
               state_dbg, reg_write, alu_op, alu_src_b);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd5 || reg_write !== 1'b1 ||
        wb_sel !== 2'b00 || alu_op !== 4'b0000)
      $display("FAIL add_wb st=%0d rw=%b wb=%b op=%b exp 5,1,00,0000",
               state_dbg, reg_write, wb_sel, alu_op);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd1 || reg_write !== 1'b0)
      $display("FAIL add_refetch st=%0d rw=%b exp 1,0",
               state_dbg, reg_write);
    else passed++;
  endtask

  task automatic test_lw();
    int reqs;
    start();
    set_ir(32'h0000_A083);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (mem_req === 1'b1) reqs++;
      if (i < 3 && ir_write !== 1'b0) reqs = 99;
      if (i == 3 && ir_write !== 1'b1) reqs = 99;
      if (i < 3) nxt();
    end
    total++;
    if (reqs !== 4)
      $display("FAIL lw_fetch_wait req_cycles=%0d exp 4", reqs);
    else passed++;
    nxt(); mem_ready = 1'b0; #1;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd3 || alu_src_b !== 1'b1 ||
        alu_op !== 4'b0000)
      $display("FAIL lw_exec st=%0d sb=%b op=%b exp 3,1,0000",
               state_dbg, alu_src_b, alu_op);
    else passed++;
    nxt(); mem_ready = 1'b1; #1;
    total++;
    if (state_dbg !== 3'd4 || mem_req !== 1'b1 ||
        mem_addr_sel !== 1'b1 || mem_we !== 1'b0 ||
        mdr_write !== 1'b1)
      $display("FAIL lw_mem st=%0d req=%b as=%b we=%b mdr=%b exp 4,1,1,0,1",
               state_dbg, mem_req, mem_addr_sel, mem_we, mdr_write);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd5 || reg_write !== 1'b1 ||
        wb_sel !== 2'b01 || mdr_write !== 1'b0)
      $display("FAIL lw_wb st=%0d rw=%b wb=%b mdr=%b exp 5,1,01,0",
               state_dbg, reg_write, wb_sel, mdr_write);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd1)
      $display("FAIL lw_refetch st=%0d exp 1", state_dbg);
    else passed++;
  endtask

  task automatic test_branch();
    start();
    set_ir(32'h0000_0063);
    mem_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      #1;
      nxt(); #1;
      nxt(); branch_cond = (t == 1); #1;
      total++;
      if (state_dbg !== 3'd3 || pc_write !== (t == 1) ||
          pc_src !== 2'b01 || alu_op !== 4'b0001 ||
          reg_write !== 1'b0)
        $display("FAIL beq_exec%0d st=%0d pw=%b ps=%b op=%b rw=%b exp 3,%0d,01,0001,0",
                 t, state_dbg, pc_write, pc_src, alu_op,
                 reg_write, t);
      else passed++;
      nxt(); branch_cond = 1'b0; #1;
      total++;
      if (state_dbg !== 3'd1)
        $display("FAIL beq_back%0d st=%0d exp 1", t, state_dbg);
      else passed++;
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] w [6];
    logic [3:0]  eop [6];
    logic        esb [6];
    w   = '{32'h4020_8033, 32'h4020_D033, 32'h0000_3013,
            32'h4000_5013, 32'h0000_4013, 32'h0000_1017};
    eop = '{4'b0001, 4'b0111, 4'b1001,
            4'b0111, 4'b0100, 4'b0000};
    esb = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      start();
      set_ir(w[k]);
      mem_ready = 1'b1; #1;
      nxt(); #1;
      nxt(); #1;
      total++;
      if (state_dbg !== 3'd3 || alu_op !== eop[k] ||
          alu_src_b !== esb[k] ||
          alu_src_a !== (k == 5))
        $display("FAIL alu_exec%0d st=%0d op=%b sb=%b sa=%b exp 3,%b,%b,%0d",
                 k, state_dbg, alu_op, alu_src_b, alu_src_a,
                 eop[k], esb[k], k == 5);
      else passed++;
      nxt(); #1;
      total++;
      if (state_dbg !== 3'd5 || reg_write !== 1'b1 ||
          alu_op !== eop[k])
        $display("FAIL alu_wb%0d st=%0d rw=%b op=%b exp 5,1,%b",
                 k, state_dbg, reg_write, alu_op, eop[k]);
      else passed++;
    end
  endtask

  task automatic test_jumps();
    logic [31:0] w [3];
    logic [6:0]  ev [3];
    logic [6:0]  got;
    w  = '{32'h0000_006F, 32'h0000_8067, 32'h0000_00B7};
    ev = '{7'b1_01_1_10_0, 7'b1_10_1_10_1,
           7'b0_00_1_11_0};
    start();
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ir(w[k]); #1;
      total++;
      if (state_dbg !== 3'd1 || ir_write !== 1'b1)
        $display("FAIL jmp_fetch%0d st=%0d ir=%b exp 1,1",
                 k, state_dbg, ir_write);
      else passed++;
      nxt(); #1;
      nxt(); #1;
      got = {pc_write, pc_src, reg_write, wb_sel, alu_src_b};
      total++;
      if (state_dbg !== 3'd3 || got !== ev[k])
        $display("FAIL jmp_exec%0d st=%0d ctl=%b exp 3,%b",
                 k, state_dbg, got, ev[k]);
      else passed++;
      nxt();
    end
  endtask

  task automatic test_illegal();
    start();
    set_ir(32'h0200_0033);
    mem_ready = 1'b1; #1;
    nxt(); #1;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd6 || trap !== 1'b1 ||
        trap_cause !== 1'b0 || reg_write !== 1'b0 ||
        mem_req !== 1'b0)
      $display("FAIL illegal_trap st=%0d trap=%b cause=%b rw=%b req=%b exp 6,1,0,0,0",
               state_dbg, trap, trap_cause, reg_write, mem_req);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd6 || ir_write !== 1'b0 ||
        pc_write !== 1'b0)
      $display("FAIL illegal_sticky st=%0d ir=%b pw=%b exp 6,0,0",
               state_dbg, ir_write, pc_write);
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    start();
    set_ir(32'h0000_A083);
    mem_ready = 1'b1; #1;
    nxt(); mem_ready = 1'b0; #1;
    nxt(); #1;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nxt(); #1;
      if (state_dbg !== 3'd4 || mem_req !== 1'b1 ||
          mdr_write !== 1'b0)
        ok = 1'b0;
    end
    total++;
    if (!ok)
      $display("FAIL timeout_wait early exit st=%0d exp 4",
               state_dbg);
    else passed++;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd6 || trap !== 1'b1 ||
        trap_cause !== 1'b1 || mem_req !== 1'b0 ||
        reg_write !== 1'b0)
      $display("FAIL timeout_trap st=%0d trap=%b cause=%b req=%b rw=%b exp 6,1,1,0,0",
               state_dbg, trap, trap_cause, mem_req, reg_write);
    else passed++;
    rst = 1'b1; #1;
    total++;
    if (state_dbg !== 3'd0 || trap !== 1'b0 ||
        trap_cause !== 1'b0)
      $display("FAIL timeout_rst st=%0d trap=%b cause=%b exp 0,0,0",
               state_dbg, trap, trap_cause);
    else passed++;
  endtask

  task automatic test_rst_store();
    start();
    set_ir(32'h0020_A023);
    mem_ready = 1'b1; #1;
    nxt(); mem_ready = 1'b0; #1;
    nxt(); #1;
    nxt(); #1;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd4 || mem_req !== 1'b1 ||
        mem_we !== 1'b1 || mem_addr_sel !== 1'b1)
      $display("FAIL sw_wait st=%0d req=%b we=%b as=%b exp 4,1,1,1",
               state_dbg, mem_req, mem_we, mem_addr_sel);
    else passed++;
    #2 rst = 1'b1; #1;
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 ||
        state_dbg !== 3'd0)
      $display("FAIL sw_async_rst req=%b we=%b st=%0d exp 0,0,0",
               mem_req, mem_we, state_dbg);
    else passed++;
    nxt(); rst = 1'b0;
    nxt(); #1;
    total++;
    if (state_dbg !== 3'd1 || mem_req !== 1'b1 ||
        mem_we !== 1'b0 || mem_addr_sel !== 1'b0)
      $display("FAIL sw_refetch st=%0d req=%b we=%b as=%b exp 1,1,0,0",
               state_dbg, mem_req, mem_we, mem_addr_sel);
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_alu_ops();
    test_jumps();
    test_illegal();
    test_timeout();
    test_rst_store();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
